// File: rtl/cache_pkg.sv
// Shared types and geometry for the 4-way set-associative cache controller.
// A line is {valid, tag, data}, packed MSB-first into 36 bits.
package cache_pkg;

    localparam int TAG_W     = 3;
    localparam int INDEX_W   = 4;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = 16;
    localparam int ADDR_W    = TAG_W + INDEX_W;
    localparam int NUM_WAYS  = 4;
    localparam int NUM_SETS  = 1 << INDEX_W;
    localparam int LINE_W    = 36;
    localparam int VALID_BIT = 35;
    localparam int TAG_MSB   = 34;
    localparam int TAG_LSB   = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_RD,
        FILL,
        MEM_WR,
        DONE
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } line_t;

    // Keeps only the lowest set bit; way 1 (bit 0) has the highest priority.
    function automatic logic [NUM_WAYS-1:0] lowest_onehot(input logic [NUM_WAYS-1:0] v);
        logic [NUM_WAYS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (v[i] && (r == '0)) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/cache_ctrl_fsm_victim.sv
// Victim way selection: first invalid way, otherwise a per-set round-robin
// pointer that only moves when it actually supplied the victim.
module victim_select
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [INDEX_W-1:0]  index,
    input  logic                advance,
    output logic [NUM_WAYS-1:0] victim
);

    logic [1:0] ptr [NUM_SETS];
    logic       all_valid;

    assign all_valid = &valid;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        victim = '0;
        if (all_valid) begin
            victim[ptr[index]] = 1'b1;
        end else begin
            victim = lowest_onehot(~valid);
        end
    end

    // NOTE: the pointer file is tiny and its reset value is architectural, so it is
    // reset like ordinary flops; sequential state always uses non-blocking <=.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) ptr[s] <= '0;
        end else if (advance && all_valid) begin
            ptr[index] <= ptr[index] + 2'd1;
        end
    end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Request sequencer for the 4-way cache: lookup, read-miss fill from memory,
// write-through without allocate, saturating hit/miss statistics.
module cache_ctrl_fsm
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_done,
    output logic [INDEX_W-1:0]  arr_index,
    input  logic [LINE_W-1:0]   line_1,
    input  logic [LINE_W-1:0]   line_2,
    input  logic [LINE_W-1:0]   line_3,
    input  logic [LINE_W-1:0]   line_4,
    input  logic                hit_1,
    input  logic                hit_2,
    input  logic                hit_3,
    input  logic                hit_4,
    output logic [NUM_WAYS-1:0] arr_we,
    output logic [LINE_W-1:0]   arr_wline,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);

    state_t              state;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic                req_we;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W-1:0]   fill_data;

    logic [NUM_WAYS-1:0] hits;
    logic [NUM_WAYS-1:0] hit_way;
    logic                any_hit;
    logic [NUM_WAYS-1:0] valids;
    logic [NUM_WAYS-1:0] victim;
    logic [DATA_W-1:0]   hit_data;

    assign hits    = {hit_4, hit_3, hit_2, hit_1};
    assign hit_way = lowest_onehot(hits);
    assign any_hit = |hits;
    assign valids  = {line_4[VALID_BIT], line_3[VALID_BIT], line_2[VALID_BIT], line_1[VALID_BIT]};

    // Tag compare happens outside this block; the tag fields are only passed through.
    logic unused_line_tags;
    assign unused_line_tags = ^{line_1[TAG_MSB:TAG_LSB], line_2[TAG_MSB:TAG_LSB],
                                line_3[TAG_MSB:TAG_LSB], line_4[TAG_MSB:TAG_LSB]};

    always_comb begin
        hit_data = line_4[DATA_W-1:0];
        if (hit_1)      hit_data = line_1[DATA_W-1:0];
        else if (hit_2) hit_data = line_2[DATA_W-1:0];
        else if (hit_3) hit_data = line_3[DATA_W-1:0];
    end

    victim_select u_victim (
        .clk     (clk),
        .rst     (rst),
        .valid   (valids),
        .index   (req_index),
        .advance (state == MEM_RD && mem_ack),
        .victim  (victim)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_tag   <= '0;
            req_index <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            fill_data <= '0;
            cpu_rdata <= '0;
            cpu_done  <= 1'b0;
            arr_index <= '0;
            arr_we    <= '0;
            arr_wline <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            arr_we   <= '0;
            cpu_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_req && !cpu_done) begin
                        req_tag   <= cpu_addr[ADDR_W-1:INDEX_W];
                        req_index <= cpu_addr[INDEX_W-1:0];
                        req_we    <= cpu_we;
                        req_wdata <= cpu_wdata;
                        arr_index <= cpu_addr[INDEX_W-1:0];
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (any_hit) hit_cnt  <= sat_inc(hit_cnt);
                    else         miss_cnt <= sat_inc(miss_cnt);
                    if (req_we) begin
                        if (any_hit) begin
                            arr_we    <= hit_way;
                            arr_wline <= line_t'{valid: 1'b1, tag: req_tag, data: req_wdata};
                        end
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {req_tag, req_index};
                        mem_wdata <= req_wdata;
                        state     <= MEM_WR;
                    end else if (any_hit) begin
                        cpu_rdata <= hit_data;
                        cpu_done  <= 1'b1;
                        state     <= DONE;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {req_tag, req_index};
                        state    <= MEM_RD;
                    end
                end
                // The fill write is issued on the ack edge so arr_we is high during FILL.
                MEM_RD: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_addr  <= '0;
                        fill_data <= mem_rdata;
                        arr_we    <= victim;
                        arr_wline <= line_t'{valid: 1'b1, tag: req_tag, data: mem_rdata};
                        state     <= FILL;
                    end
                end
                FILL: begin
                    cpu_rdata <= fill_data;
                    cpu_done  <= 1'b1;
                    state     <= DONE;
                end
                MEM_WR: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        cpu_done  <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    arr_index <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Self-checking bench for cache_ctrl_fsm: a transaction-level model predicts
// array writes, memory traffic, read data, latency and counters per request.
module tb_cache_ctrl_fsm;
    import cache_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0]  cpu_addr = '0;
    logic [DATA_W-1:0]  cpu_wdata = '0;
    logic [DATA_W-1:0]  cpu_rdata;
    logic               cpu_done;
    logic [INDEX_W-1:0] arr_index;
    logic [LINE_W-1:0]  line_1 = '0, line_2 = '0, line_3 = '0, line_4 = '0;
    logic               hit_1 = 1'b0, hit_2 = 1'b0, hit_3 = 1'b0, hit_4 = 1'b0;
    logic [3:0]         arr_we;
    logic [LINE_W-1:0]  arr_wline;
    logic               mem_req, mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               mem_ack = 1'b0;
    logic [DATA_W-1:0]  mem_rdata = '0;
    logic [CNT_W-1:0]   hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    cache_ctrl_fsm dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .arr_index(arr_index),
        .line_1(line_1), .line_2(line_2), .line_3(line_3), .line_4(line_4),
        .hit_1(hit_1), .hit_2(hit_2), .hit_3(hit_3), .hit_4(hit_4),
        .arr_we(arr_we), .arr_wline(arr_wline),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: counters and per-set round-robin pointers.
    int m_hit = 0, m_miss = 0;
    int rr [16];

    // Expectations for the transaction in flight.
    bit          mon_en = 1'b0;
    bit          exp_mem = 1'b0, exp_mem_we = 1'b0, exp_read = 1'b0;
    logic [6:0]  exp_addr = '0;
    logic [31:0] exp_wdata = '0, exp_rdata = '0;
    logic [3:0]  exp_arr_we = '0;
    logic [35:0] exp_wline = '0;
    int          saw_mem = 0, saw_we = 0, saw_done = 0;
    logic [3:0]  last_arr_we = '0;
    logic [35:0] last_wline = '0;
    logic [31:0] last_rdata = '0;
    logic [6:0]  last_mem_addr = '0;

    // Compare process: checks every cycle in which an output carries meaning.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!exp_mem) check("no_mem_req", mem_req, 0);
            if (mem_req) begin
                saw_mem++;
                last_mem_addr = mem_addr;
                check("mem_we", mem_we, exp_mem_we);
                check("mem_addr", mem_addr, exp_addr);
                if (exp_mem_we) check("mem_wdata", mem_wdata, exp_wdata);
                check("arr_index_mem", arr_index, exp_addr[3:0]);
            end
            if (arr_we != 4'b0000) begin
                saw_we++;
                last_arr_we = arr_we;
                last_wline  = arr_wline;
                check("arr_we", arr_we, exp_arr_we);
                check("arr_wline", arr_wline, exp_wline);
                check("arr_index_we", arr_index, exp_addr[3:0]);
            end
            if (cpu_done) begin
                saw_done++;
                last_rdata = cpu_rdata;
                if (exp_read) check("cpu_rdata", cpu_rdata, exp_rdata);
                check("hit_cnt", hit_cnt, m_hit);
                check("miss_cnt", miss_cnt, m_miss);
                check("arr_index_done", arr_index, exp_addr[3:0]);
            end
        end
    end

    task automatic do_txn(input bit we, input logic [6:0] addr, input logic [31:0] wdata,
                          input logic [3:0] hv, input logic [35:0] l1, input logic [35:0] l2,
                          input logic [35:0] l3, input logic [35:0] l4,
                          input logic [31:0] md, input int dly);
        logic [35:0] lv [4];
        int  hit_idx, vic, k, mem_first, exp_k;
        bit  got_done, ack_pending;
        lv[0] = l1; lv[1] = l2; lv[2] = l3; lv[3] = l4;

        hit_idx = -1;
        for (int i = 0; i < 4; i++) if (hv[i] && hit_idx < 0) hit_idx = i;
        exp_read   = !we;
        exp_mem    = we || (hit_idx < 0);
        exp_mem_we = we;
        exp_addr   = addr;
        exp_wdata  = wdata;
        exp_arr_we = '0;
        exp_wline  = '0;
        exp_rdata  = '0;
        if (hit_idx >= 0) begin
            if (m_hit < 65535) m_hit++;
            if (we) begin
                exp_arr_we[hit_idx] = 1'b1;
                exp_wline = {1'b1, addr[6:4], wdata};
            end else begin
                exp_rdata = lv[hit_idx][31:0];
            end
        end else begin
            if (m_miss < 65535) m_miss++;
            if (!we) begin
                vic = -1;
                for (int i = 0; i < 4; i++) if (!lv[i][35] && vic < 0) vic = i;
                if (vic < 0) begin
                    vic = rr[addr[3:0]];
                    rr[addr[3:0]] = (vic + 1) % 4;
                end
                exp_arr_we[vic] = 1'b1;
                exp_wline = {1'b1, addr[6:4], md};
                exp_rdata = md;
            end
        end
        // Read hit: done 2 cycles after acceptance; misses: mem_req at +2, then ack delay.
        exp_k = (hit_idx >= 0 && !we) ? 2 : (we ? 3 + dly : 4 + dly);

        saw_mem = 0; saw_we = 0; saw_done = 0;
        @(negedge clk);
        line_1 = l1; line_2 = l2; line_3 = l3; line_4 = l4;
        {hit_4, hit_3, hit_2, hit_1} = hv;
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;

        k = 0; mem_first = -1; got_done = 1'b0; ack_pending = 1'b0;
        while (!got_done && k < 60) begin
            @(negedge clk);
            k++;
            if (ack_pending) begin
                mem_ack = 1'b0;
                mem_rdata = '0;
                ack_pending = 1'b0;
                check("mem_req_drop", mem_req, 0);
            end
            if (cpu_done) begin
                got_done = 1'b1;
            end else if (mem_req) begin
                if (mem_first < 0) begin
                    mem_first = k;
                    check("mem_req_latency", k, 2);
                end
                if (k - mem_first == dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = md;
                    ack_pending = 1'b1;
                end
            end
        end
        check("done_seen", got_done, 1);
        check("done_latency", k, exp_k);
        cpu_req = 1'b0;
        @(negedge clk);
        check("done_pulse", cpu_done, 0);
        check("mem_seen", saw_mem > 0, exp_mem);
        check("arr_we_pulses", saw_we, exp_arr_we != 4'b0000);
        check("done_count", saw_done, 1);
        {hit_4, hit_3, hit_2, hit_1} = 4'b0000;
        exp_mem = 1'b0;
        exp_arr_we = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0]  vict_lit [5];
    logic [35:0] full3 [4];

    initial begin
        for (int s = 0; s < 16; s++) rr[s] = 0;
        vict_lit[0] = 4'b0001; vict_lit[1] = 4'b0010; vict_lit[2] = 4'b0100;
        vict_lit[3] = 4'b1000; vict_lit[4] = 4'b0001;

        // 1. Reset values, then idle with no request.
        repeat (2) @(negedge clk);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_cpu_done", cpu_done, 0);
        check("rst_arr_index", arr_index, 0);
        check("rst_arr_we", arr_we, 0);
        check("rst_arr_wline", arr_wline, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_mem_req", mem_req, 0);
            check("idle_arr_we", arr_we, 0);
            check("idle_cpu_done", cpu_done, 0);
        end

        // 2. Cold read miss on tag 1, index 5.
        do_txn(1'b0, 7'h15, 32'h0, 4'b0000, 36'h0, 36'h0, 36'h0, 36'h0, 32'hDEADBEEF, 3);
        check("t2_mem_addr", last_mem_addr, 7'h15);
        check("t2_arr_we", last_arr_we, 4'b0001);
        check("t2_arr_wline", last_wline, 36'h9DEADBEEF);
        check("t2_rdata", last_rdata, 32'hDEADBEEF);
        check("t2_miss_cnt", miss_cnt, 1);

        // 3. Read hits: way 2, then ways 3+4 together (way 3 wins).
        do_txn(1'b0, 7'h15, 32'h0, 4'b0010, 36'h9DEADBEEF, 36'h9CAFEF00D, 36'h0, 36'h0, 32'h0, 1);
        check("t3_rdata", last_rdata, 32'hCAFEF00D);
        check("t3_no_mem", saw_mem, 0);
        check("t3_hit_cnt", hit_cnt, 1);
        do_txn(1'b0, 7'h15, 32'h0, 4'b1100, 36'h0, 36'h0, 36'h900003333, 36'h900004444, 32'h0, 1);
        check("t3_multi_rdata", last_rdata, 32'h00003333);

        // 4. Write hit way 1, write hit ways 2+3, write miss.
        do_txn(1'b1, 7'h15, 32'h12345678, 4'b0001, 36'h9DEADBEEF, 36'h0, 36'h0, 36'h0, 32'h0, 2);
        check("t4_arr_we", last_arr_we, 4'b0001);
        check("t4_arr_wline", last_wline, 36'h912345678);
        do_txn(1'b1, 7'h15, 32'hA5A5A5A5, 4'b0110, 36'h0, 36'h0, 36'h0, 36'h0, 32'h0, 0);
        check("t4_multi_arr_we", last_arr_we, 4'b0010);
        do_txn(1'b1, 7'h2A, 32'h0BADF00D, 4'b0000, 36'h0, 36'h0, 36'h0, 36'h0, 32'h0, 1);
        check("t4_miss_no_we", saw_we, 0);

        // 5. Set 3 fully valid: round-robin victims.
        full3[0] = 36'h811110000; full3[1] = 36'h922220000;
        full3[2] = 36'hA33330000; full3[3] = 36'hB44440000;
        for (int n = 0; n < 5; n++) begin
            do_txn(1'b0, 7'h53, 32'h0, 4'b0000, full3[0], full3[1], full3[2], full3[3],
                   32'h5000_0000 + 32'(n), 2);
            check("t5_victim", last_arr_we, vict_lit[n]);
        end
        check("t5_hit_cnt", hit_cnt, 4);
        check("t5_miss_cnt", miss_cnt, 7);

        // 6. Reset while waiting on memory, then a clean read.
        mon_en = 1'b0;
        @(negedge clk);
        line_1 = '0; line_2 = '0; line_3 = '0; line_4 = '0;
        cpu_we = 1'b0; cpu_addr = 7'h37; cpu_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_req) break;
        end
        check("t6_mem_req_pre", mem_req, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_mem_req_async", mem_req, 0);
        check("t6_arr_we_async", arr_we, 0);
        check("t6_miss_cnt_async", miss_cnt, 0);
        cpu_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t6_no_done", cpu_done, 0);
            check("t6_no_we", arr_we, 0);
            check("t6_no_mem", mem_req, 0);
        end
        rst = 1'b0;
        m_hit = 0; m_miss = 0;
        for (int s = 0; s < 16; s++) rr[s] = 0;
        mon_en = 1'b1;
        do_txn(1'b0, 7'h37, 32'h0, 4'b0000, 36'h0, 36'h0, 36'h0, 36'h0, 32'h7777AAAA, 1);
        check("t6_after_rdata", last_rdata, 32'h7777AAAA);
        check("t6_after_arr_we", last_arr_we, 4'b0001);
        check("t6_after_miss_cnt", miss_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
